// File: rtl/alu.sv
// 16-bit integer ALU. The result and flags are computed combinationally and then
// registered, so they appear one clock after the inputs are sampled.
module alu #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic [3:0]       opcode,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned MSB = WIDTH - 1;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_AND   = 4'h3;
  localparam logic [3:0] OP_OR    = 4'h4;
  localparam logic [3:0] OP_XOR   = 4'h5;
  localparam logic [3:0] OP_NOT   = 4'h6;
  localparam logic [3:0] OP_SHL   = 4'h7;
  localparam logic [3:0] OP_SHR   = 4'h8;
  localparam logic [3:0] OP_INC   = 4'h9;
  localparam logic [3:0] OP_DEC   = 4'hA;
  localparam logic [3:0] OP_PASSB = 4'hB;
  localparam logic [3:0] OP_NEG   = 4'hC;
  localparam logic [3:0] OP_CMP   = 4'hD;

  logic [WIDTH-1:0] result_d, result_q;
  logic             zero_q, negative_q;
  logic             carry_d, carry_q;
  logic             overflow_d, overflow_q;

  logic [WIDTH-1:0] op_b;
  logic [WIDTH:0]   add_w, sub_w, shl_w, shr_w;
  logic [SHW-1:0]   shamt;

  // INC/DEC reuse the ADD/SUB paths with B forced to one.
  always_comb begin
    op_b  = ((opcode == OP_INC) || (opcode == OP_DEC)) ? WIDTH'(1) : num2;
    shamt = num2[SHW-1:0];
    add_w = {1'b0, num1} + {1'b0, op_b};
    sub_w = {1'b0, num1} - {1'b0, op_b};
    shl_w = {1'b0, num1} << shamt;
    shr_w = {num1, 1'b0} >> shamt;
  end

  always_comb begin
    result_d   = '0;
    carry_d    = 1'b0;
    overflow_d = 1'b0;
    case (opcode)
      OP_NOP:   result_d = num1;
      OP_ADD, OP_INC: begin
        result_d   = add_w[WIDTH-1:0];
        carry_d    = add_w[WIDTH];
        overflow_d = (num1[MSB] == op_b[MSB]) && (add_w[MSB] != num1[MSB]);
      end
      OP_SUB, OP_DEC: begin
        result_d   = sub_w[WIDTH-1:0];
        carry_d    = sub_w[WIDTH];
        overflow_d = (num1[MSB] != op_b[MSB]) && (sub_w[MSB] != num1[MSB]);
      end
      OP_AND:   result_d = num1 & num2;
      OP_OR:    result_d = num1 | num2;
      OP_XOR:   result_d = num1 ^ num2;
      OP_NOT:   result_d = ~num1;
      // The extra bit beyond the shifted word holds the last bit shifted out.
      OP_SHL: begin
        result_d = shl_w[WIDTH-1:0];
        carry_d  = shl_w[WIDTH];
      end
      OP_SHR: begin
        result_d = shr_w[WIDTH:1];
        carry_d  = shr_w[0];
      end
      OP_PASSB: result_d = num2;
      OP_NEG: begin
        result_d   = '0 - num1;
        overflow_d = (num1 == {1'b1, {(WIDTH-1){1'b0}}});
      end
      OP_CMP: begin
        result_d[0] = $signed(num1) < $signed(num2);
        carry_d     = num1 < num2;
      end
      default: result_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q   <= '0;
      zero_q     <= 1'b1;
      negative_q <= 1'b0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      result_q   <= result_d;
      zero_q     <= (result_d == '0);
      negative_q <= result_d[MSB];
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
    end
  end

  assign result   = result_q;
  assign zero     = zero_q;
  assign negative = negative_q;
  assign carry    = carry_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, reset corner cases, and
// random vectors checked against an integer-arithmetic reference model.
module tb_alu;

  logic        clk;
  logic        reset;
  logic [15:0] num1, num2;
  logic [3:0]  opcode;
  logic [15:0] result;
  logic        zero, negative, carry, overflow;

  int n_vec;
  int n_err;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  op;
    logic [15:0] res;
    logic        z, n, c, v;
    string       name;
  } vec_t;

  vec_t tbl[$];

  alu #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .num1(num1), .num2(num2), .opcode(opcode),
    .result(result), .zero(zero), .negative(negative), .carry(carry),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b,
                              input logic [3:0] op, input logic [15:0] res,
                              input logic z, input logic n, input logic c,
                              input logic v, input string name);
    vec_t t;
    t.a = a; t.b = b; t.op = op; t.res = res;
    t.z = z; t.n = n; t.c = c; t.v = v; t.name = name;
    return t;
  endfunction

  // Reference model in plain integer arithmetic.
  function automatic vec_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic [3:0] op);
    vec_t t;
    int ua, ub, sa, sb, r, s, x;
    logic c, v;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    c = 1'b0; v = 1'b0; r = 0;
    s = ub % 16;
    case (op)
      4'h0: r = ua;
      4'h1: begin r = (ua + ub) % 65536; c = (ua + ub) > 65535;
                  x = sa + sb; v = (x > 32767) || (x < -32768); end
      4'h2: begin r = (ua - ub + 65536) % 65536; c = ua < ub;
                  x = sa - sb; v = (x > 32767) || (x < -32768); end
      4'h3: r = ua & ub;
      4'h4: r = ua | ub;
      4'h5: r = ua ^ ub;
      4'h6: r = 65535 - ua;
      4'h7: begin r = (ua * (1 << s)) % 65536;
                  c = (s != 0) && (((ua >> (16 - s)) & 1) == 1); end
      4'h8: begin r = ua / (1 << s);
                  c = (s != 0) && (((ua >> (s - 1)) & 1) == 1); end
      4'h9: begin r = (ua + 1) % 65536; c = ua == 65535; v = sa == 32767; end
      4'hA: begin r = (ua + 65535) % 65536; c = ua == 0; v = sa == -32768; end
      4'hB: r = ub;
      4'hC: begin r = (65536 - ua) % 65536; v = sa == -32768; end
      4'hD: begin r = (sa < sb) ? 1 : 0; c = ua < ub; end
      default: r = 0;
    endcase
    t.a = a; t.b = b; t.op = op;
    t.res = 16'(r);
    t.z = (r == 0);
    t.n = (r >= 32768);
    t.c = c; t.v = v; t.name = "rand";
    return t;
  endfunction

  task automatic check(input string name, input logic [15:0] er, input logic ez,
                       input logic en, input logic ec, input logic ev);
    n_vec++;
    if ({result, zero, negative, carry, overflow} !== {er, ez, en, ec, ev}) begin
      n_err++;
      $display("FAIL %s: got res=%h z%b n%b c%b v%b, want res=%h z%b n%b c%b v%b",
               name, result, zero, negative, carry, overflow, er, ez, en, ec, ev);
    end
  endtask

  // Drive at edge+1, capture at the next edge, sample 1 time unit later.
  task automatic apply(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
    num1 = a; num2 = b; opcode = op;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t e, prev;
    n_vec = 0; n_err = 0;

    tbl.push_back(mk(16'h0009, 16'h0003, 4'h1, 16'h000C, 0, 0, 0, 0, "seq_add"));
    tbl.push_back(mk(16'h0009, 16'h0003, 4'h2, 16'h0006, 0, 0, 0, 0, "seq_sub"));
    tbl.push_back(mk(16'h0009, 16'h0003, 4'h3, 16'h0001, 0, 0, 0, 0, "seq_and"));
    tbl.push_back(mk(16'h0009, 16'h0003, 4'h4, 16'h000B, 0, 0, 0, 0, "seq_or"));
    tbl.push_back(mk(16'h0009, 16'h0003, 4'h5, 16'h000A, 0, 0, 0, 0, "seq_xor"));
    tbl.push_back(mk(16'h0009, 16'h0003, 4'h6, 16'hFFF6, 0, 1, 0, 0, "seq_not"));
    tbl.push_back(mk(16'hFFFF, 16'h0001, 4'h1, 16'h0000, 1, 0, 1, 0, "add_wrap"));
    tbl.push_back(mk(16'h7FFF, 16'h0001, 4'h1, 16'h8000, 0, 1, 0, 1, "add_ovf"));
    tbl.push_back(mk(16'h0003, 16'h0009, 4'h2, 16'hFFFA, 0, 1, 1, 0, "sub_borrow"));
    tbl.push_back(mk(16'h8000, 16'h0001, 4'h2, 16'h7FFF, 0, 0, 0, 1, "sub_ovf"));
    tbl.push_back(mk(16'h8000, 16'h0000, 4'hC, 16'h8000, 0, 1, 0, 1, "neg_min"));
    tbl.push_back(mk(16'h0001, 16'h0000, 4'hC, 16'hFFFF, 0, 1, 0, 0, "neg_one"));
    tbl.push_back(mk(16'h8001, 16'h0001, 4'h7, 16'h0002, 0, 0, 1, 0, "shl_1"));
    tbl.push_back(mk(16'h0003, 16'h0001, 4'h8, 16'h0001, 0, 0, 1, 0, "shr_1"));
    tbl.push_back(mk(16'h1234, 16'h0010, 4'h7, 16'h1234, 0, 0, 0, 0, "shl_0"));
    tbl.push_back(mk(16'hFFFE, 16'h0001, 4'hD, 16'h0001, 0, 0, 0, 0, "cmp_signed"));
    tbl.push_back(mk(16'hFFFF, 16'h0000, 4'h9, 16'h0000, 1, 0, 1, 0, "inc_wrap"));
    tbl.push_back(mk(16'h0000, 16'h0000, 4'hA, 16'hFFFF, 0, 1, 1, 0, "dec_wrap"));
    tbl.push_back(mk(16'h0005, 16'h0005, 4'hE, 16'h0000, 1, 0, 0, 0, "rsv_e"));
    tbl.push_back(mk(16'hFFFF, 16'hFFFF, 4'hF, 16'h0000, 1, 0, 0, 0, "rsv_f"));
    tbl.push_back(mk(16'h8000, 16'h1111, 4'h0, 16'h8000, 0, 1, 0, 0, "nop"));
    tbl.push_back(mk(16'hABCD, 16'h0000, 4'hB, 16'h0000, 1, 0, 0, 0, "passb_zero"));

    // Reset is seen asynchronously, before any clock edge.
    reset = 1'b1; num1 = 16'h0009; num2 = 16'h0003; opcode = 4'h1;
    #2;
    check("reset_async", 16'h0000, 1, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("reset_release", 16'h000C, 0, 0, 0, 0);

    // Directed table; between edges, new inputs must not reach the outputs.
    prev = tbl[0];
    for (int i = 0; i < tbl.size(); i++) begin
      e = tbl[i];
      num1 = e.a; num2 = e.b; opcode = e.op;
      if (i > 0) begin
        #1;
        check({e.name, "_hold"}, prev.res, prev.z, prev.n, prev.c, prev.v);
      end
      @(posedge clk);
      #1;
      check(e.name, e.res, e.z, e.n, e.c, e.v);
      prev = e;
    end

    // Reset pulse between edges during an active stream.
    apply(16'h1234, 16'h1111, 4'h1);
    check("stream_pre", 16'h2345, 0, 0, 0, 0);
    num1 = 16'h0009; num2 = 16'h0003; opcode = 4'h2;
    reset = 1'b1;
    #1;
    check("midreset_clear", 16'h0000, 1, 0, 0, 0);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("midreset_resume", 16'h0006, 0, 0, 0, 0);

    // Random vectors with a bias toward boundary operands.
    for (int i = 0; i < 400; i++) begin
      logic [15:0] a, b;
      logic [3:0]  op;
      a  = 16'($urandom);
      b  = 16'($urandom);
      op = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 5))
        0: a = 16'hFFFF;
        1: a = 16'h8000;
        2: a = 16'h7FFF;
        3: b = 16'h0000;
        default: ;
      endcase
      e = model(a, b, op);
      apply(a, b, op);
      check($sformatf("rand%0d_op%h", i, op), e.res, e.z, e.n, e.c, e.v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, want done");
    $fatal(1);
  end

endmodule
